video_pattern_source: RTL and testbench
=======================================

VIDEO_PATTERN_SOURCE -- requirements
Module: video_pattern_source

Interface
REQ-001 Parameters SHALL be: H_RES, default 320, pixels per line; V_RES, default 240, lines per frame.
REQ-002 clk  input  1  single clock; all logic is rising-edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 mm_slave_chipselect  input  1  register access select.
REQ-005 mm_slave_address  input  3  register index; only 0-3 are decoded.
REQ-006 mm_slave_write  input  1  write strobe.
REQ-007 mm_slave_writedata  input  32  write data.
REQ-008 mm_slave_read  input  1  read strobe.
REQ-009 mm_slave_readdata  output  32  read data.
REQ-010 irq_sender  output  1  frame-done interrupt, level-sensitive.
REQ-011 source_valid_out  output  1  Avalon-ST valid.
REQ-012 source_ready_in  input  1  Avalon-ST ready from the downstream sink; readyLatency 0.
REQ-013 source_data_out  output  16  RGB565 pixel.
REQ-014 source_startofpacket_out  output  1  first pixel of frame.
REQ-015 source_endofpacket_out  output  1  last pixel of frame.

Function
REQ-016 Register map SHALL be:
- reg0: run[0], single_shot[1], irq_enable[2].
- reg1: pattern_sel[1:0].
- reg2: solid_color[15:0].
- reg3, read-only status: busy[0], irq_pending[1], frame_count[31:16].
- Writing 1 to reg3[1] SHALL clear irq_pending.
REQ-017 Readdata SHALL be registered, valid 1 cycle after read && chipselect; unused bits read 0; addresses 4-7 read 0 and ignore writes.
REQ-018 The FSM SHALL have states IDLE, STREAM, and LAST.
- IDLE -> STREAM when run=1.
- STREAM -> LAST when the pixel at x=H_RES-1, y=V_RES-2 transfers.
- LAST -> IDLE or STREAM on the final-pixel transfer.
REQ-019 On entering STREAM, pattern_sel and solid_color SHALL be latched into shadow registers; register writes during a frame SHALL take effect only at the next frame.
REQ-020 A transfer SHALL occur exactly on cycles with source_valid_out && source_ready_in; x and y counters advance only on a transfer.
REQ-021 While source_valid_out=1 and source_ready_in=0, data/sop/eop SHALL hold stable.
REQ-022 source_valid_out SHALL be 1 in STREAM and LAST, and 0 in IDLE.
REQ-023 sop SHALL be 1 only for x=0,y=0; eop SHALL be 1 only for x=H_RES-1,y=V_RES-1.
REQ-024 x SHALL wrap to 0 after H_RES-1, incrementing y; y SHALL wrap to 0 after V_RES-1.
REQ-025 Patterns SHALL be:
- 00: solid_color.
- 01: 8 vertical bars of width H_RES/8 (integer division; the last bar extends to the line end), colours in order FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
- 10: ramp {x[8:4], x[8:3], x[8:4]}.
- 11: checkerboard, FFFF when x[3]^y[3]=1, else 0000.
REQ-026 On the final-pixel transfer:
- frame_count SHALL increment, wrapping at 65535.
- irq_pending SHALL be set.
- If single_shot=1, run SHALL clear and the FSM SHALL go to IDLE; otherwise the next state is STREAM if run=1, else IDLE.
REQ-027 Clearing run mid-frame SHALL NOT truncate the frame; the current frame completes and the FSM then goes to IDLE.
REQ-028 If a register clear of irq_pending coincides with a frame-done set, the set SHALL win.
REQ-029 irq_sender SHALL equal irq_pending && irq_enable.
REQ-030 busy SHALL be 1 whenever the FSM is not in IDLE.

Reset
REQ-031 While reset=0, all outputs SHALL be 0, the FSM SHALL be in IDLE, and all counters and registers SHALL be 0.
REQ-032 Reset asserted mid-frame SHALL drop valid immediately with no eop; after release the next frame SHALL start with sop at x=0,y=0.

Structure
REQ-033 A shared package SHALL hold:
- register address constants;
- pattern_sel encodings;
- FSM state encoding;
- the 8-entry colour-bar table.
REQ-034 Pixel colour generation SHALL be a combinational sub-module, video_pattern_gen(x, y, pattern, solid_color -> pixel).

Verification (H_RES=16, V_RES=2)
REQ-035 Write reg2=F800, reg1=0, reg0=1, with ready=1 always -> 32 consecutive transfers of F800; sop on the 1st, eop on the 32nd; next frame sop follows with no gap.
REQ-036 pattern 01, ready toggling every cycle:
- bars of width 2;
- pixels x=0..15 = FFFF,FFFF,FFE0,FFE0,...,0000,0000;
- data stable during ready=0;
- exactly 32 transfers per frame.
REQ-037 Write reg0=3 (single_shot) with irq_enable=0 -> exactly one frame, then busy=0 and irq_pending=1 with irq_sender=0; then write reg0=4 -> irq_sender=1; then write reg3=2 -> irq_sender=0.
REQ-038 Write reg1=3 at pixel 5 of a pattern-00 frame -> the rest of the frame stays solid; the next frame is checkerboard with x=8..15 on y=0 equal to FFFF.
REQ-039 Write reg0=0 mid-frame -> the frame completes with eop, then valid=0; frame_count increments by 1.
REQ-040 Assert reset at pixel 10 -> valid=0 in the same cycle and frame_count=0; after release, sop at the first pixel.

Source files
------------

// File: rtl/video_pattern_source_pkg.sv
// Shared definitions for the video pattern source: register map, pattern
// encodings, FSM state encoding and the colour-bar palette.
package video_pattern_source_pkg;

    localparam logic [2:0] ADDR_CTRL    = 3'd0;
    localparam logic [2:0] ADDR_PATTERN = 3'd1;
    localparam logic [2:0] ADDR_COLOR   = 3'd2;
    localparam logic [2:0] ADDR_STATUS  = 3'd3;

    typedef enum logic [1:0] {
        PAT_SOLID   = 2'b00,
        PAT_BARS    = 2'b01,
        PAT_RAMP    = 2'b10,
        PAT_CHECKER = 2'b11
    } pattern_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_LAST   = 2'd2
    } state_t;

    // RGB565 colour-bar palette, left to right across the line
    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_color = 16'hFFFF;
            3'd1:    bar_color = 16'hFFE0;
            3'd2:    bar_color = 16'h07FF;
            3'd3:    bar_color = 16'h07E0;
            3'd4:    bar_color = 16'hF81F;
            3'd5:    bar_color = 16'hF800;
            3'd6:    bar_color = 16'h001F;
            default: bar_color = 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/video_pattern_gen.sv
// Combinational RGB565 pixel generator: maps a pixel coordinate and the
// frame's latched pattern settings to a colour.
module video_pattern_gen
    import video_pattern_source_pkg::*;
#(
    parameter int H_RES = 320
) (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [1:0]  pattern,
    input  logic [15:0] solid_color,
    output logic [15:0] pixel
);

    localparam int BAR_W = H_RES / 8;

    logic [2:0] w_bar_idx;
    logic       w_unused;

    // only y[3] matters (checkerboard); the rest of y is intentionally ignored
    assign w_unused = &{1'b0, y[15:4], y[2:0]};

    // bar index = number of bar boundaries at or left of x; the last bar
    // absorbs the remainder of H_RES/8 so it runs to the end of the line
    always_comb begin
        w_bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if ({16'd0, x} >= 32'(k * BAR_W)) begin
                w_bar_idx = 3'(k);
            end
        end
    end

    // pattern select
    always_comb begin
        case (pattern)
            PAT_SOLID: pixel = solid_color;
            PAT_BARS:  pixel = bar_color(w_bar_idx);
            PAT_RAMP:  pixel = {x[8:4], x[8:3], x[8:4]};
            default:   pixel = (x[3] ^ y[3]) ? 16'hFFFF : 16'h0000;
        endcase
    end

endmodule

// File: rtl/video_pattern_source.sv
// Avalon-MM configured test-pattern generator streaming RGB565 frames over
// Avalon-ST (readyLatency 0) with frame-done interrupt.
module video_pattern_source
    import video_pattern_source_pkg::*;
#(
    parameter int H_RES = 320,
    parameter int V_RES = 240
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mm_slave_chipselect,
    input  logic [2:0]  mm_slave_address,
    input  logic        mm_slave_write,
    input  logic [31:0] mm_slave_writedata,
    input  logic        mm_slave_read,
    output logic [31:0] mm_slave_readdata,
    output logic        irq_sender,
    output logic        source_valid_out,
    input  logic        source_ready_in,
    output logic [15:0] source_data_out,
    output logic        source_startofpacket_out,
    output logic        source_endofpacket_out
);

    localparam logic [15:0] X_LAST   = 16'(H_RES - 1);
    localparam logic [15:0] Y_LAST   = 16'(V_RES - 1);
    localparam logic [15:0] Y_PENULT = 16'(V_RES - 2);

    state_t      r_state;
    logic [15:0] r_x;
    logic [15:0] r_y;
    logic        r_run;
    logic        r_single_shot;
    logic        r_irq_enable;
    logic [1:0]  r_pattern_sel;
    logic [15:0] r_solid_color;
    logic        r_irq_pending;
    logic [15:0] r_frame_count;
    logic [1:0]  r_sh_pattern;
    logic [15:0] r_sh_color;

    logic        w_wr;
    logic        w_rd;
    logic        w_valid;
    logic        w_xfer;
    logic        w_x_end;
    logic        w_frame_done;
    logic [15:0] w_pixel;
    logic        w_unused;

    assign w_wr         = mm_slave_chipselect && mm_slave_write;
    assign w_rd         = mm_slave_chipselect && mm_slave_read;
    assign w_valid      = (r_state != ST_IDLE);
    assign w_xfer       = w_valid && source_ready_in;
    assign w_x_end      = (r_x == X_LAST);
    assign w_frame_done = (r_state == ST_LAST) && w_xfer && w_x_end;
    assign w_unused     = &{1'b0, mm_slave_writedata[31:16]};

    // control/status registers; frame-done events override same-cycle CPU writes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_run         <= 1'b0;
            r_single_shot <= 1'b0;
            r_irq_enable  <= 1'b0;
            r_pattern_sel <= 2'b00;
            r_solid_color <= 16'd0;
            r_irq_pending <= 1'b0;
            r_frame_count <= 16'd0;
        end else begin
            if (w_wr) begin
                case (mm_slave_address)
                    ADDR_CTRL: begin
                        r_run         <= mm_slave_writedata[0];
                        r_single_shot <= mm_slave_writedata[1];
                        r_irq_enable  <= mm_slave_writedata[2];
                    end
                    ADDR_PATTERN: r_pattern_sel <= mm_slave_writedata[1:0];
                    ADDR_COLOR:   r_solid_color <= mm_slave_writedata[15:0];
                    ADDR_STATUS:  if (mm_slave_writedata[1]) r_irq_pending <= 1'b0;
                    default: ;
                endcase
            end
            if (w_frame_done) begin
                r_irq_pending <= 1'b1;
                r_frame_count <= r_frame_count + 16'd1;
                if (r_single_shot) r_run <= 1'b0;
            end
        end
    end

    // registered read data, one cycle after a selected read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mm_slave_readdata <= 32'd0;
        end else if (w_rd) begin
            case (mm_slave_address)
                ADDR_CTRL:    mm_slave_readdata <= {29'd0, r_irq_enable, r_single_shot, r_run};
                ADDR_PATTERN: mm_slave_readdata <= {30'd0, r_pattern_sel};
                ADDR_COLOR:   mm_slave_readdata <= {16'd0, r_solid_color};
                ADDR_STATUS:  mm_slave_readdata <= {r_frame_count, 14'd0, r_irq_pending, w_valid};
                default:      mm_slave_readdata <= 32'd0;
            endcase
        end
    end

    // frame FSM and raster counters; pattern settings are snapshotted at frame start
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_x          <= 16'd0;
            r_y          <= 16'd0;
            r_sh_pattern <= 2'b00;
            r_sh_color   <= 16'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_run) begin
                        r_state      <= ST_STREAM;
                        r_sh_pattern <= r_pattern_sel;
                        r_sh_color   <= r_solid_color;
                    end
                end
                ST_STREAM: begin
                    if (w_xfer) begin
                        if (w_x_end) begin
                            r_x <= 16'd0;
                            r_y <= r_y + 16'd1;
                            if (r_y == Y_PENULT) r_state <= ST_LAST;
                        end else begin
                            r_x <= r_x + 16'd1;
                        end
                    end
                end
                ST_LAST: begin
                    if (w_xfer) begin
                        if (w_x_end) begin
                            r_x <= 16'd0;
                            r_y <= 16'd0;
                            if (!r_single_shot && r_run) begin
                                r_state      <= ST_STREAM;
                                r_sh_pattern <= r_pattern_sel;
                                r_sh_color   <= r_solid_color;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_x <= r_x + 16'd1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    video_pattern_gen #(.H_RES(H_RES)) u_gen (
        .x           (r_x),
        .y           (r_y),
        .pattern     (r_sh_pattern),
        .solid_color (r_sh_color),
        .pixel       (w_pixel)
    );

    assign source_valid_out         = w_valid;
    assign source_data_out          = w_valid ? w_pixel : 16'd0;
    assign source_startofpacket_out = w_valid && (r_x == 16'd0) && (r_y == 16'd0);
    assign source_endofpacket_out   = w_valid && w_x_end && (r_y == Y_LAST);
    assign irq_sender               = r_irq_pending && r_irq_enable;

endmodule

// File: tb/tb_video_pattern_source.sv
// Randomized bench for video_pattern_source against a frame-level reference model.
module tb_video_pattern_source;

    localparam int H    = 16;
    localparam int V    = 2;
    localparam int NPIX = H * V;

    logic        clk;
    logic        reset;
    logic        cs;
    logic [2:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic        rd;
    logic [31:0] rdata;
    logic        irq;
    logic        valid;
    logic        ready;
    logic [15:0] data;
    logic        sop;
    logic        eop;

    video_pattern_source #(.H_RES(H), .V_RES(V)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .mm_slave_chipselect      (cs),
        .mm_slave_address         (addr),
        .mm_slave_write           (wr),
        .mm_slave_writedata       (wdata),
        .mm_slave_read            (rd),
        .mm_slave_readdata        (rdata),
        .irq_sender               (irq),
        .source_valid_out         (valid),
        .source_ready_in          (ready),
        .source_data_out          (data),
        .source_startofpacket_out (sop),
        .source_endofpacket_out   (eop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // reference model state
    logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    int          p;
    int          m_frames;
    int          xfers;
    logic        m_run, m_ss, m_ien, m_irqp, m_busy;
    logic [1:0]  m_pat, f_pat;
    logic [15:0] m_col, f_col;
    logic        held_v;
    logic [17:0] held;
    int          rmode;

    function automatic logic [15:0] ref_pix(input int x, input int y,
                                            input logic [1:0] pat, input logic [15:0] col);
        int b, r, g;
        case (pat)
            2'd0: return col;
            2'd1: begin
                b = x / (H / 8);
                if (b > 7) b = 7;
                return bars[b];
            end
            2'd2: begin
                r = (x / 16) % 32;
                g = (x / 8) % 64;
                return 16'((r * 2048) + (g * 32) + r);
            end
            default: return (((x / 8) % 2) != ((y / 8) % 2)) ? 16'hFFFF : 16'h0000;
        endcase
    endfunction

    // stream monitor: every transfer is checked against the model frame
    always @(negedge clk) begin
        if (!reset) begin
            p      = 0;
            held_v = 1'b0;
        end else begin
            if (held_v)
                chk("hold", {13'd0, valid, sop, eop, data}, {13'd0, 1'b1, held});
            held_v = valid && !ready;
            held   = {sop, eop, data};
            if (valid && ready) begin
                chk("pix", 32'(data), 32'(ref_pix(p % H, p / H, f_pat, f_col)));
                chk("sop", 32'(sop), 32'(p == 0));
                chk("eop", 32'(eop), 32'(p == NPIX - 1));
                xfers++;
                if (p == NPIX - 1) begin
                    p = 0;
                    m_frames++;
                    m_irqp = 1'b1;
                    if (m_ss) m_run = 1'b0;
                    m_busy = m_run;
                    if (m_busy) begin
                        f_pat = m_pat;
                        f_col = m_col;
                    end
                end else begin
                    p++;
                end
            end
        end
    end

    // downstream ready generator
    initial begin
        ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       ready = 1'b1;
                1:       ready = ~ready;
                default: ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic model_reset();
        m_run = 0; m_ss = 0; m_ien = 0; m_irqp = 0; m_busy = 0;
        m_pat = 0; m_col = 0; f_pat = 0; f_col = 0;
        m_frames = 0; p = 0;
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
        cs = 1; wr = 1; addr = a; wdata = d;
        @(posedge clk);
        #1;
        cs = 0; wr = 0;
        case (a)
            3'd0: begin
                m_run = d[0]; m_ss = d[1]; m_ien = d[2];
                if (d[0] && !m_busy) begin
                    m_busy = 1'b1; p = 0; f_pat = m_pat; f_col = m_col;
                end
            end
            3'd1: m_pat = d[1:0];
            3'd2: m_col = d[15:0];
            3'd3: if (d[1]) m_irqp = 1'b0;
            default: ;
        endcase
    endtask

    task automatic rd_reg(input logic [2:0] a, output logic [31:0] d);
        cs = 1; rd = 1; addr = a;
        @(posedge clk);
        #1;
        cs = 0; rd = 0;
        d = rdata;
    endtask

    task automatic chk_status(input string tag);
        logic [31:0] d;
        rd_reg(3'd3, d);
        chk(tag, d, {16'(m_frames), 14'd0, m_irqp, m_busy});
    endtask

    task automatic wait_frames(input int target);
        int n = 0;
        while (m_frames < target && n < 5000) begin
            @(negedge clk); #2; n++;
        end
        if (m_frames < target) chk("timeout_frames", 32'(m_frames), 32'(target));
    endtask

    task automatic wait_pix(input int q);
        int n = 0;
        while (p != q && n < 5000) begin
            @(negedge clk); #2; n++;
        end
        if (p != q) chk("timeout_pix", 32'(p), 32'(q));
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk); #2;
        while (valid && n < 5000) begin
            @(negedge clk); #2; n++;
        end
        chk("idle_valid", 32'(valid), 32'd0);
        chk("idle_model", 32'(m_busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int t, fc0;
        logic ss, ien;
        reset = 0; cs = 0; wr = 0; rd = 0; addr = 0; wdata = 0; rmode = 0;
        xfers = 0; held_v = 0; held = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_sop_eop", {30'd0, sop, eop}, 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        reset = 1;
        chk_status("status_reset");

        // unused address space
        wr_reg(3'd6, 32'hFFFF_FFFF);
        rd_reg(3'd6, d); chk("addr6_read", d, 32'd0);
        rd_reg(3'd0, d); chk("reg0_after_addr6", d, {29'd0, m_ien, m_ss, m_run});

        // solid colour, continuous ready, back-to-back frames
        rmode = 0;
        wr_reg(3'd2, 32'h0000_F800);
        wr_reg(3'd1, 32'd0);
        rd_reg(3'd2, d); chk("reg2_read", d, {16'd0, m_col});
        wr_reg(3'd0, 32'd1);
        wait_frames(1);
        t = xfers;
        repeat (NPIX) begin @(negedge clk); #2; end
        chk("no_gap", 32'(xfers - t), 32'(NPIX));
        repeat (3) begin @(negedge clk); #2; end
        wr_reg(3'd0, 32'd0);
        wait_frames(3);
        wait_idle();
        chk_status("status_solid");

        // stop mid-frame: frame completes, count advances by one
        fc0 = m_frames;
        wr_reg(3'd0, 32'd1);
        wait_pix(12);
        wr_reg(3'd0, 32'd0);
        wait_frames(fc0 + 1);
        wait_idle();
        rd_reg(3'd3, d);
        chk("stop_midframe_count", {16'd0, d[31:16]}, 32'(fc0 + 1));
        chk("stop_midframe_busy", 32'(d[0]), 32'd0);

        // colour bars with ready toggling
        wr_reg(3'd3, 32'd2);
        rmode = 1;
        wr_reg(3'd1, 32'd1);
        t = m_frames;
        wr_reg(3'd0, 32'd1);
        wait_frames(t + 2);
        wait_pix(4);
        wr_reg(3'd0, 32'd0);
        wait_frames(t + 3);
        wait_idle();
        chk_status("status_bars");

        // single shot, interrupt masking and clearing
        wr_reg(3'd3, 32'd2);
        rmode = 2;
        t = m_frames;
        wr_reg(3'd0, 32'd3);
        wait_frames(t + 1);
        wait_idle();
        repeat (6) begin @(negedge clk); #2; end
        chk("ss_stopped", 32'(valid), 32'd0);
        chk("ss_frames", 32'(m_frames), 32'(t + 1));
        chk_status("status_ss");
        chk("ss_irq_masked", 32'(irq), 32'(m_irqp & m_ien));
        wr_reg(3'd0, 32'd4);
        chk("irq_enabled", 32'(irq), 32'(m_irqp & m_ien));
        wr_reg(3'd3, 32'd2);
        chk("irq_cleared", 32'(irq), 32'(m_irqp & m_ien));

        // pattern change mid-frame takes effect next frame
        rmode = 0;
        wr_reg(3'd2, $urandom);
        wr_reg(3'd1, 32'd0);
        t = m_frames;
        wr_reg(3'd0, 32'd1);
        wait_pix(5);
        wr_reg(3'd1, 32'd3);
        wait_frames(t + 1);
        wait_pix(20);
        wr_reg(3'd0, 32'd0);
        wait_frames(t + 2);
        wait_idle();

        // randomized frames
        for (int i = 0; i < 8; i++) begin
            rmode = 2;
            wr_reg(3'd1, 32'($urandom_range(0, 3)));
            wr_reg(3'd2, $urandom);
            ss  = 1'($urandom_range(0, 1));
            ien = 1'($urandom_range(0, 1));
            t = m_frames;
            wr_reg(3'd0, {29'd0, ien, ss, 1'b1});
            wait_frames(t + 1);
            if (!ss) begin
                wait_pix(3);
                wr_reg(3'd0, {29'd0, ien, 2'b00});
                wait_frames(t + 2);
            end
            wait_idle();
            chk_status("status_rand");
            chk("rand_irq", 32'(irq), 32'(m_irqp & m_ien));
        end

        // asynchronous reset mid-frame
        rmode = 0;
        wr_reg(3'd1, 32'd2);
        t = m_frames;
        wr_reg(3'd0, 32'd1);
        wait_pix(10);
        reset = 0;
        model_reset();
        #1;
        chk("rst_mid_valid", 32'(valid), 32'd0);
        chk("rst_mid_sop_eop", {30'd0, sop, eop}, 32'd0);
        chk("rst_mid_data", 32'(data), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
        chk_status("status_after_rst");
        wr_reg(3'd1, 32'd2);
        wr_reg(3'd0, 32'd1);
        wait_frames(1);
        wait_pix(7);
        wr_reg(3'd0, 32'd0);
        wait_frames(2);
        wait_idle();
        chk_status("status_final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
